bram_dp_controller: RTL and testbench

- Parametrised successor to the single-port BRAM write/readback controller.
- Fills a true dual-port BRAM region on port 0 with a seeded incrementing pattern, then reads it back on port 1, streaming the data out.
- Start address, length and seed are programmable, and addresses wrap modulo MEM_SIZE.
- Sits between a host sequencer and a true_dpbram instance, and serves as the memory self-test / fill engine.

---
 rtl/bram_dp_controller.sv | 153 +++++++++++++++
 tb/tb_bram_dp_controller.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bram_dp_controller.sv
// bram_dp_controller: fills a dual-port BRAM region on port 0 with seed+idx, then reads it back
// on port 1 and streams it out. Ports: clk/reset_n, run/len/base/seed in, status, port0, port1, stream.
// Optional build macro BRAM_DP_CTRL_CHECK_EN adds a readback comparator driving o_err_cnt.
module bram_dp_controller #(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 7,
  parameter int MEM_SIZE = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_run,
  input  logic [AWIDTH:0]   i_num_cnt,
  input  logic [AWIDTH-1:0] i_base_addr,
  input  logic [DWIDTH-1:0] i_seed,
  output logic              o_idle,
  output logic              o_write,
  output logic              o_read,
  output logic              o_done,
  output logic [AWIDTH-1:0] addr0,
  output logic              ce0,
  output logic              we0,
  output logic [DWIDTH-1:0] d0,
  output logic [AWIDTH-1:0] addr1,
  output logic              ce1,
  output logic              we1,
  input  logic [DWIDTH-1:0] q1,
  output logic              o_valid,
  output logic [DWIDTH-1:0] o_mem_data,
  output logic [AWIDTH:0]   o_err_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [AWIDTH:0]   N_MAX  = (AWIDTH+1)'(MEM_SIZE);
  localparam logic [AWIDTH-1:0] A_LAST = AWIDTH'(MEM_SIZE-1);

  logic [1:0]        state;
  logic [AWIDTH:0]   n;
  logic [AWIDTH:0]   idx;
  logic [AWIDTH-1:0] base;
  logic [AWIDTH-1:0] ptr;
  logic [DWIDTH-1:0] seed;
  logic [DWIDTH-1:0] data;
  logic              rd_en;
  logic              vld;

  logic              st_idle;
  logic              st_write;
  logic              st_read;
  logic              st_done;
  logic [AWIDTH-1:0] ptr_nxt;
  logic [AWIDTH:0]   n_clamp;

  assign st_idle  = (state == S_IDLE);
  assign st_write = (state == S_WRITE);
  assign st_read  = (state == S_READ);
  assign st_done  = (state == S_DONE);

  // Wrap at MEM_SIZE-1 so non power-of-2 depths work.
  assign ptr_nxt = (ptr == A_LAST) ? '0 : ptr + 1'b1;
  assign n_clamp = (i_num_cnt > N_MAX) ? N_MAX : i_num_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      n     <= '0;
      idx   <= '0;
      base  <= '0;
      ptr   <= '0;
      seed  <= '0;
      data  <= '0;
      rd_en <= 1'b0;
      vld   <= 1'b0;
    end else begin
      vld <= rd_en;
      unique case (1'b1)
        st_idle: begin
          if (i_run) begin
            n     <= n_clamp;
            base  <= i_base_addr;
            seed  <= i_seed;
            ptr   <= i_base_addr;
            data  <= i_seed;
            idx   <= '0;
            state <= (n_clamp == '0) ? S_DONE : S_WRITE;
          end
        end
        st_write: begin
          ptr  <= ptr_nxt;
          data <= data + 1'b1;
          idx  <= idx + 1'b1;
          if (idx == n - 1'b1) begin
            state <= S_READ;
            ptr   <= base;
            data  <= seed;
            idx   <= '0;
            rd_en <= 1'b1;
          end
        end
        st_read: begin
          // data tracks the expected word of the next valid beat.
          if (rd_en) begin
            ptr <= ptr_nxt;
            if (idx == n - 1'b1) rd_en <= 1'b0;
          end
          if (vld) data <= data + 1'b1;
          idx <= idx + 1'b1;
          // One extra cycle lets the last read data drain.
          if (idx == n) state <= S_DONE;
        end
        st_done: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BRAM_DP_CTRL_CHECK_EN
  logic [AWIDTH:0] err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err <= '0;
    end else if (st_idle && i_run) begin
      err <= '0;
    end else if (vld && (q1 != data) && (err != '1)) begin
      err <= err + 1'b1;
    end
  end

  assign o_err_cnt = err;
`else
  assign o_err_cnt = '0;
`endif

  assign o_idle     = st_idle;
  assign o_write    = st_write;
  assign o_read     = st_read;
  assign o_done     = st_done;
  assign ce0        = st_write;
  assign we0        = st_write;
  assign addr0      = st_write ? ptr : '0;
  assign d0         = st_write ? data : '0;
  assign ce1        = rd_en;
  assign we1        = 1'b0;
  assign addr1      = rd_en ? ptr : '0;
  assign o_valid    = vld;
  assign o_mem_data = vld ? q1 : '0;

endmodule

// File: tb/tb_bram_dp_controller.sv
// tb_bram_dp_controller: table-driven directed bench with a behavioural dual-port BRAM.
// Checks addresses, data, counts, latency, clamping, ignored re-run, reset abort, error count.
module tb_bram_dp_controller;

  localparam int DW = 16;
  localparam int AW = 7;
  localparam int MS = 128;

`ifdef BRAM_DP_CTRL_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_run;
  logic [AW:0]   i_num_cnt;
  logic [AW-1:0] i_base_addr;
  logic [DW-1:0] i_seed;
  logic          o_idle, o_write, o_read, o_done;
  logic [AW-1:0] addr0, addr1;
  logic          ce0, we0, ce1, we1;
  logic [DW-1:0] d0, q1;
  logic          o_valid;
  logic [DW-1:0] o_mem_data;
  logic [AW:0]   o_err_cnt;
  logic          corrupt_req = 1'b0;

  logic [DW-1:0] mem [MS];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bram_dp_controller #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk(clk), .reset_n(reset_n), .i_run(i_run),
    .i_num_cnt(i_num_cnt), .i_base_addr(i_base_addr), .i_seed(i_seed),
    .o_idle(o_idle), .o_write(o_write), .o_read(o_read), .o_done(o_done),
    .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0),
    .addr1(addr1), .ce1(ce1), .we1(we1), .q1(q1),
    .o_valid(o_valid), .o_mem_data(o_mem_data), .o_err_cnt(o_err_cnt)
  );

  always @(posedge clk) begin
    if (ce0 && we0) mem[addr0] <= d0;
    if (corrupt_req) mem[5] <= mem[5] ^ 16'h00FF;
    if (ce1) q1 <= mem[addr1];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_idle"}, o_idle, 1);
    chk({tag, "_wr"}, {o_write, o_read, o_done}, 0);
    chk({tag, "_p0"}, {ce0, we0, addr0, d0}, 0);
    chk({tag, "_p1"}, {ce1, we1, addr1}, 0);
    chk({tag, "_out"}, {o_valid, o_mem_data, o_err_cnt}, 0);
  endtask

  task automatic run_one(input int base, input int ncnt, input int seed,
                         input bit corrupt, input int pulse_at,
                         input int exp_n, input int abort_rd);
    int wc = 0;
    int rc = 0;
    int vc = 0;
    int done_cyc = -1;
    int ea;
    int ed;
    int exp_err;
    exp_err = corrupt ? CHK : 0;
    @(negedge clk);
    chk("idle_before", o_idle, 1);
    i_base_addr = AW'(base);
    i_num_cnt   = (AW+1)'(ncnt);
    i_seed      = DW'(seed);
    i_run       = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      i_run = (c == pulse_at);
      if (c == pulse_at) begin
        i_num_cnt   = 5;
        i_base_addr = 3;
        i_seed      = 16'h7777;
      end
      corrupt_req = 1'b0;
      chk("port_excl", ce0 & ce1, 0);
      if (ce0) begin
        ea = base + wc;
        if (ea >= MS) ea -= MS;
        chk("wr_addr", addr0, ea);
        chk("wr_data", d0, (seed + wc) & 16'hFFFF);
        chk("wr_we", we0, 1);
        wc++;
      end
      if (ce1) begin
        if (rc == abort_rd) begin
          reset_n = 1'b0;
          #1;
          chk_all_zero("abort");
          return;
        end
        ea = base + rc;
        if (ea >= MS) ea -= MS;
        chk("rd_addr", addr1, ea);
        chk("rd_we1", we1, 0);
        if (corrupt && rc == 0) corrupt_req = 1'b1;
        rc++;
      end
      if (o_valid) begin
        ed = (seed + vc) & 16'hFFFF;
        if (corrupt && vc == 5) ed = ed ^ 16'h00FF;
        chk("rd_stream", o_mem_data, ed);
        vc++;
      end
      if (o_done) begin
        done_cyc = c;
        chk("err_at_done", o_err_cnt, exp_err);
        break;
      end
    end
    chk("latency", done_cyc, (exp_n == 0) ? 1 : 2 * exp_n + 2);
    chk("n_writes", wc, exp_n);
    chk("n_reads", rc, exp_n);
    chk("n_valids", vc, exp_n);
    @(negedge clk);
    chk("idle_after", o_idle, 1);
    chk("done_pulse", o_done, 0);
    chk("err_hold", o_err_cnt, exp_err);
  endtask

  typedef struct {
    int base;
    int ncnt;
    int seed;
    bit corrupt;
    int pulse_at;
    int exp_n;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{0, 100, 0, 1'b0, -1, 100};
    tbl[1] = '{120, 16, 16'hFFF8, 1'b0, -1, 16};
    tbl[2] = '{0, 0, 16'h1234, 1'b0, -1, 0};
    tbl[3] = '{10, 200, 16'h0055, 1'b0, 20, 128};
    tbl[4] = '{0, 10, 16'h0100, 1'b1, -1, 10};

    reset_n     = 1'b0;
    i_run       = 1'b0;
    i_num_cnt   = '0;
    i_base_addr = '0;
    i_seed      = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      run_one(tbl[i].base, tbl[i].ncnt, tbl[i].seed, tbl[i].corrupt,
              tbl[i].pulse_at, tbl[i].exp_n, -1);
    end

    run_one(0, 100, 16'h2000, 1'b0, -1, 100, 40);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_quiet", {o_done, o_valid, ce0, ce1}, 0);
      chk("abort_idle", o_idle, 1);
    end
    reset_n = 1'b1;
    run_one(7, 10, 16'h0042, 1'b0, -1, 10, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
